alu_cmd_sequencer: RTL and testbench

Upstream command stage for the small ALU. Buffers operand/opcode commands in a small FIFO and issues them to the ALU one at a time. Holds start until done, captures the result, and returns it on a valid/ready response channel. Handles no_op and illegal opcodes locally, enforces a post-multiply drain gap, and aborts hung operations with a watchdog.

---
 rtl/alu_cmd_sequencer_pkg.sv | 31 +++
 rtl/alu_cmd_sequencer_if.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 49 ++++
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, the queued command
// record, sequencer states and an opcode legality helper.
package alu_pkg;

    typedef enum logic [2:0] {
        NO_OP  = 3'd0,
        ADD_OP = 3'd1,
        AND_OP = 3'd2,
        XOR_OP = 3'd3,
        MUL_OP = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        DRAIN
    } seq_state_e;

    // Opcodes 000..100 are defined; 101..111 are reported back as errors.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response channels of the sequencer. The slave modport is
// the sequencer's view; master is the surrounding system (source, ALU, sink).
interface alu_cmd_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;

    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_A, alu_B, alu_op, alu_start,
               rsp_valid, rsp_result, rsp_op, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_A, alu_B, alu_op, alu_start,
               rsp_valid, rsp_result, rsp_op, rsp_err
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Head entry is visible on dout while not empty;
// pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t din,
    output alu_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; a flush on reset simply realigns both pointers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers alone define which entries are valid.
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued commands to the ALU one at a time, returns each result on a
// valid/ready channel, answers no_op/illegal opcodes locally, spaces commands
// after a multiply and aborts operations whose done never arrives.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int DRAIN      = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_cmd_sequencer_if.slave  bus,
    output logic                busy
);

    import alu_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int DR_W = $clog2(DRAIN + 1);

    alu_cmd_t   fifo_din;
    alu_cmd_t   head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    seq_state_e state, state_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        start_q, start_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [2:0]  rsp_op_q, rsp_op_d;
    logic        rsp_err_q, rsp_err_d;
    logic [WD_W-1:0] wd_cnt, wd_cnt_d;
    logic [DR_W-1:0] dr_cnt, dr_cnt_d;

    assign fifo_din = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};

    alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.cmd_valid && !fifo_full),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.cmd_ready  = !fifo_full;
    assign bus.alu_A      = alu_a_q;
    assign bus.alu_B      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_start  = start_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = !fifo_empty || (state != IDLE);

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            start_q      <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
            wd_cnt       <= '0;
            dr_cnt       <= '0;
        end else begin
            state        <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            start_q      <= start_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
            wd_cnt       <= wd_cnt_d;
            dr_cnt       <= dr_cnt_d;
        end
    end

    // Next-state and next-output decode; alu_done only matters in ISSUE.
    always_comb begin
        // NOTE: every output gets a hold/default value first so no latch is inferred.
        state_d      = state;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        start_d      = start_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        wd_cnt_d     = wd_cnt;
        dr_cnt_d     = dr_cnt;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_legal_op(head.op) && head.op != NO_OP) begin
                        alu_a_d  = head.a;
                        alu_b_d  = head.b;
                        alu_op_d = head.op;
                        start_d  = 1'b1;
                        wd_cnt_d = '0;
                        state_d  = ISSUE;
                    end else begin
                        rsp_result_d = '0;
                        rsp_op_d     = head.op;
                        rsp_err_d    = (head.op != NO_OP);
                        state_d      = RESP;
                    end
                end
            end
            ISSUE: begin
                if (bus.alu_done) begin
                    rsp_result_d = bus.alu_result;
                    rsp_op_d     = alu_op_q;
                    rsp_err_d    = 1'b0;
                    start_d      = 1'b0;
                    state_d      = RESP;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    rsp_result_d = '0;
                    rsp_op_d     = alu_op_q;
                    rsp_err_d    = 1'b1;
                    start_d      = 1'b0;
                    state_d      = RESP;
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (rsp_op_q == MUL_OP) begin
                        dr_cnt_d = '0;
                        state_d  = alu_pkg::DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            alu_pkg::DRAIN: begin
                if (dr_cnt == DR_W'(DRAIN - 1))
                    state_d = IDLE;
                else
                    dr_cnt_d = dr_cnt + DR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU
// (1-cycle add/and/xor, 4-cycle mul) and hand-computed expectations.
module tb_alu_cmd_sequencer;

    localparam int TIMEOUT   = 16;
    localparam int DRAIN_CYC = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (TIMEOUT),
        .DRAIN      (DRAIN_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Free-running observation counters, sampled on the falling edge.
    int start_total = 0;
    int rsp_total   = 0;
    always @(negedge clk) begin
        if (bus.alu_start) start_total++;
        if (bus.rsp_valid) rsp_total++;
    end

    // Behavioural ALU: serves one start pulse, done_en gates done to emulate a hang.
    logic        done_en;
    logic        done_q;
    logic [15:0] res_q;
    logic        m_active;
    logic        m_served;
    logic [2:0]  m_cnt;

    assign bus.alu_done   = done_q & done_en;
    assign bus.alu_result = res_q;

    always @(posedge clk) begin
        if (reset) begin
            done_q   <= 1'b0;
            res_q    <= '0;
            m_active <= 1'b0;
            m_served <= 1'b0;
            m_cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            if (!bus.alu_start) m_served <= 1'b0;
            if (m_active) begin
                if (m_cnt == 3'd1) begin
                    done_q   <= 1'b1;
                    m_active <= 1'b0;
                    m_served <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 3'd1;
                end
            end else if (bus.alu_start && !m_served) begin
                case (bus.alu_op)
                    3'd1:    res_q <= {8'h00, bus.alu_A} + {8'h00, bus.alu_B};
                    3'd2:    res_q <= {8'h00, bus.alu_A & bus.alu_B};
                    3'd3:    res_q <= {8'h00, bus.alu_A ^ bus.alu_B};
                    3'd4:    res_q <= 16'(bus.alu_A) * 16'(bus.alu_B);
                    default: res_q <= '0;
                endcase
                if (bus.alu_op == 3'd4) begin
                    m_active <= 1'b1;
                    m_cnt    <= 3'd3;
                end else begin
                    done_q   <= 1'b1;
                    m_served <= 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one command from a falling edge; returns on the next falling edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: cmd_ready stayed 0, op=%0d", op);
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, take it with a one-cycle rsp_ready pulse.
    task automatic wait_rsp(output logic [15:0] res, output logic [2:0] op, output logic err);
        bit ok = 0;
        res = 'x;
        op  = 'x;
        err = 1'bx;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            res = bus.rsp_result;
            op  = bus.rsp_op;
            err = bus.rsp_err;
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
            @(negedge clk);
        end else begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: no rsp_valid within 100 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.alu_start !== 1'b0 || bus.alu_A !== 8'h00 || bus.alu_B !== 8'h00 || bus.alu_op !== 3'd0) begin
            errors++;
            $display("FAIL reset_alu: start=%b A=%h B=%h op=%0d, required 0 0 0 0",
                     bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 16'h0000 || bus.rsp_op !== 3'd0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b result=%h op=%0d err=%b, required all 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: cmd_ready=%b busy=%b, required 1 0", bus.cmd_ready, busy);
        end
    endtask

    task automatic test_single_add();
        logic [15:0] r; logic [2:0] o; logic e;
        int s0 = start_total;
        push(8'hFF, 8'h01, 3'd1);
        wait_rsp(r, o, e);
        checks++;
        if (r !== 16'h0100 || o !== 3'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL single_add: result=%h op=%0d err=%b, required 0100 1 0", r, o, e);
        end
        checks++;
        if (start_total - s0 != 2) begin
            errors++;
            $display("FAIL single_add_start: alu_start high %0d cycles, required 2", start_total - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic [2:0] o; logic e;
        logic [15:0] exp_r [3] = '{16'h0030, 16'h00A5, 16'hFE01};
        logic [2:0]  exp_o [3] = '{3'd2, 3'd3, 3'd4};
        int gap = 0;
        push(8'hF0, 8'h3C, 3'd2);
        push(8'hAA, 8'h0F, 3'd3);
        push(8'hFF, 8'hFF, 3'd4);
        push(8'h12, 8'h34, 3'd1);
        for (int k = 0; k < 3; k++) begin
            wait_rsp(r, o, e);
            checks++;
            if (r !== exp_r[k] || o !== exp_o[k] || e !== 1'b0) begin
                errors++;
                $display("FAIL b2b_rsp%0d: result=%h op=%0d err=%b, required %h %0d 0",
                         k, r, o, e, exp_r[k], exp_o[k]);
            end
        end
        // DRAIN cycles in DRAIN, one IDLE cycle to pop, then start rises.
        for (int i = 0; i < 20; i++) begin
            if (bus.alu_start) break;
            gap++;
            @(negedge clk);
        end
        checks++;
        if (gap != DRAIN_CYC + 1) begin
            errors++;
            $display("FAIL mul_drain_gap: alu_start low %0d cycles after handshake, required %0d",
                     gap, DRAIN_CYC + 1);
        end
        wait_rsp(r, o, e);
        checks++;
        if (r !== 16'h0046 || o !== 3'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_drain_add: result=%h op=%0d err=%b, required 0046 1 0", r, o, e);
        end
    endtask

    task automatic test_noop_illegal();
        logic [15:0] r; logic [2:0] o; logic e;
        int s0 = start_total;
        push(8'h12, 8'h34, 3'd0);
        push(8'h56, 8'h78, 3'd6);
        wait_rsp(r, o, e);
        checks++;
        if (r !== 16'h0000 || o !== 3'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL no_op: result=%h op=%0d err=%b, required 0000 0 0", r, o, e);
        end
        wait_rsp(r, o, e);
        checks++;
        if (r !== 16'h0000 || o !== 3'd6 || e !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: result=%h op=%0d err=%b, required 0000 6 1", r, o, e);
        end
        checks++;
        if (start_total != s0) begin
            errors++;
            $display("FAIL local_ops_start: alu_start high %0d cycles, required 0", start_total - s0);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] r; logic [2:0] o; logic e;
        int s0 = start_total;
        done_en = 1'b0;
        push(8'h01, 8'h02, 3'd1);
        wait_rsp(r, o, e);
        checks++;
        if (r !== 16'h0000 || o !== 3'd1 || e !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: result=%h op=%0d err=%b, required 0000 1 1", r, o, e);
        end
        checks++;
        if (start_total - s0 != TIMEOUT || bus.alu_start !== 1'b0) begin
            errors++;
            $display("FAIL timeout_start: high %0d cycles, now %b, required %0d then 0",
                     start_total - s0, bus.alu_start, TIMEOUT);
        end
        done_en = 1'b1;
        push(8'h05, 8'h06, 3'd1);
        wait_rsp(r, o, e);
        checks++;
        if (r !== 16'h000B || o !== 3'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL post_timeout_add: result=%h op=%0d err=%b, required 000B 1 0", r, o, e);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r; logic [2:0] o; logic e;
        logic [7:0]  va [5] = '{8'h01, 8'h03, 8'h10, 8'h80, 8'hFF};
        logic [7:0]  vb [5] = '{8'h02, 8'h04, 8'h20, 8'h80, 8'hFE};
        logic [15:0] ve [5] = '{16'h0003, 16'h0007, 16'h0030, 16'h0100, 16'h01FD};
        for (int k = 0; k < 5; k++) push(va[k], vb[k], 3'd1);
        checks++;
        if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fifo_full: cmd_ready=%b busy=%b, required 0 1", bus.cmd_ready, busy);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0003 || bus.rsp_op !== 3'd1 || bus.rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL rsp_hold%0d: valid=%b result=%h op=%0d err=%b, required 1 0003 1 0",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err);
            end
        end
        for (int k = 0; k < 5; k++) begin
            wait_rsp(r, o, e);
            checks++;
            if (r !== ve[k] || o !== 3'd1 || e !== 1'b0) begin
                errors++;
                $display("FAIL bp_rsp%0d: result=%h op=%0d err=%b, required %h 1 0", k, r, o, e, ve[k]);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int r0;
        push(8'hFF, 8'hFF, 3'd4);
        for (int i = 0; i < 10 && !bus.alu_start; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.alu_start !== 1'b1) begin
            errors++;
            $display("FAIL mul_issue: alu_start=%b, required 1 before reset", bus.alu_start);
        end
        r0 = rsp_total;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.alu_start !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul: start=%b rsp_valid=%b busy=%b cmd_ready=%b, required 0 0 0 1",
                     bus.alu_start, bus.rsp_valid, busy, bus.cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rsp_total != r0) begin
            errors++;
            $display("FAIL reset_no_rsp: rsp_valid seen %0d cycles after reset, required 0", rsp_total - r0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        done_en       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b0;

        test_reset();
        test_single_add();
        test_back_to_back();
        test_noop_illegal();
        test_timeout();
        test_backpressure();
        test_reset_mid_mul();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
